// File: rtl/ate_pattern_seq.sv
// Vector-driven ATE sequencer: plays a preloaded vector memory as DRAM/Driver/Sampler
// commands, checks returned read data and tallies mismatches without software help.
//
//   state     | meaning
//   S_IDLE    | waiting for start, results held
//   S_FETCH   | vector read from memory, command outputs decoded
//   S_ISSUE   | one-cycle command pulse on the outputs
//   S_CHECK   | waiting for read data (RD) or sampling MR_OUT (MRR)
//   S_WAITCNT | inter-vector idle cycles, then advance PC
//   S_DONE    | sequence end, raise done and drop busy
module ate_pattern_seq #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 64,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          start,
    input  logic          abort,
    input  logic          cfg_strb_shift,
    input  logic [4:0]    cfg_strb_back,
    input  logic [4:0]    cfg_strb_front,
    input  logic          cfg_driv_shift,
    input  logic [4:0]    cfg_driv_front,
    input  logic [7:0]    strb_data,
    input  logic          strb_valid,
    input  logic [7:0]    mr_out,
    output logic          r,
    output logic          w,
    output logic          mrw,
    output logic          mrr,
    output logic [7:0]    addr,
    output logic [7:0]    mr_in,
    output logic [7:0]    dq_in,
    output logic          driv,
    output logic          driv_shift,
    output logic [4:0]    driv_front,
    output logic          strb,
    output logic          strb_shift,
    output logic [4:0]    strb_back,
    output logic [4:0]    strb_front,
    output logic          busy,
    output logic          done,
    output logic [7:0]    fail_cnt,
    output logic [AW-1:0] first_fail_pc,
    output logic          tmo_err,
    output logic [AW-1:0] pc
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_WR  = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_MRW = 3'd3;
    localparam logic [2:0] OP_MRR = 3'd4;
    localparam logic [2:0] OP_END = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_CHECK, S_WAITCNT, S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   fetch_word;
    logic [2:0]    cur_op;
    logic [7:0]    cur_exp;
    logic [4:0]    cur_wait;
    logic [4:0]    wait_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          chk_done;
    logic          chk_fail;
    logic          chk_tmo;

    // Memory is deliberately not reset; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (ld_en && !busy) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign fetch_word = mem[pc];

    // A valid sample in the terminal timeout cycle still counts as valid.
    always_comb begin
        chk_done = 1'b0;
        chk_fail = 1'b0;
        chk_tmo  = 1'b0;
        if (cur_op == OP_MRR) begin
            chk_done = 1'b1;
            chk_fail = (mr_out != cur_exp);
        end else if (strb_valid) begin
            chk_done = 1'b1;
            chk_fail = (strb_data != cur_exp);
        end else if (tmo_cnt == '0) begin
            chk_done = 1'b1;
            chk_fail = 1'b1;
            chk_tmo  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            r             <= 1'b0;
            w             <= 1'b0;
            mrw           <= 1'b0;
            mrr           <= 1'b0;
            addr          <= '0;
            mr_in         <= '0;
            dq_in         <= '0;
            driv          <= 1'b0;
            driv_shift    <= 1'b0;
            driv_front    <= '0;
            strb          <= 1'b0;
            strb_shift    <= 1'b0;
            strb_back     <= '0;
            strb_front    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail_cnt      <= '0;
            first_fail_pc <= '0;
            tmo_err       <= 1'b0;
            pc            <= '0;
            cur_op        <= '0;
            cur_exp       <= '0;
            cur_wait      <= '0;
            wait_cnt      <= '0;
            tmo_cnt       <= '0;
        end else begin
            r    <= 1'b0;
            w    <= 1'b0;
            mrw  <= 1'b0;
            mrr  <= 1'b0;
            driv <= 1'b0;
            strb <= 1'b0;
            if (busy && abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            pc            <= '0;
                            fail_cnt      <= '0;
                            first_fail_pc <= '0;
                            tmo_err       <= 1'b0;
                            done          <= 1'b0;
                            busy          <= 1'b1;
                            state         <= S_FETCH;
                        end
                    end
                    // Pulses are decoded here so they appear exactly during S_ISSUE.
                    S_FETCH: begin
                        cur_op   <= fetch_word[31:29];
                        cur_exp  <= fetch_word[12:5];
                        cur_wait <= fetch_word[4:0];
                        case (fetch_word[31:29])
                            OP_WR: begin
                                w          <= 1'b1;
                                driv       <= 1'b1;
                                addr       <= fetch_word[28:21];
                                dq_in      <= fetch_word[20:13];
                                driv_shift <= cfg_driv_shift;
                                driv_front <= cfg_driv_front;
                            end
                            OP_RD: begin
                                r          <= 1'b1;
                                strb       <= 1'b1;
                                addr       <= fetch_word[28:21];
                                strb_shift <= cfg_strb_shift;
                                strb_back  <= cfg_strb_back;
                                strb_front <= cfg_strb_front;
                            end
                            OP_MRW: begin
                                mrw   <= 1'b1;
                                addr  <= fetch_word[28:21];
                                mr_in <= fetch_word[20:13];
                            end
                            OP_MRR: begin
                                mrr  <= 1'b1;
                                addr <= fetch_word[28:21];
                            end
                            default: ;
                        endcase
                        state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        tmo_cnt  <= TW'(TIMEOUT - 1);
                        wait_cnt <= cur_wait;
                        case (cur_op)
                            OP_RD, OP_MRR: state <= S_CHECK;
                            OP_END:        state <= S_DONE;
                            default:       state <= S_WAITCNT;
                        endcase
                    end
                    S_CHECK: begin
                        if (chk_done) begin
                            if (chk_fail) begin
                                if (fail_cnt != 8'hFF) begin
                                    fail_cnt <= fail_cnt + 8'd1;
                                end
                                if (fail_cnt == 8'd0) begin
                                    first_fail_pc <= pc;
                                end
                            end
                            if (chk_tmo) begin
                                tmo_err <= 1'b1;
                            end
                            state <= S_WAITCNT;
                        end else begin
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
                    end
                    S_WAITCNT: begin
                        if (wait_cnt != 5'd0) begin
                            wait_cnt <= wait_cnt - 5'd1;
                        end else if (pc == AW'(DEPTH - 1)) begin
                            state <= S_DONE;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ate_pattern_seq.sv
// Directed bench for ate_pattern_seq: single-vector table plus multi-vector corner sequences.
module tb_ate_pattern_seq;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          start, abort;
    logic          cfg_strb_shift, cfg_driv_shift;
    logic [4:0]    cfg_strb_back, cfg_strb_front, cfg_driv_front;
    logic [7:0]    strb_data, mr_out;
    logic          strb_valid;
    logic          r, w, mrw, mrr, driv, strb;
    logic [7:0]    addr, mr_in, dq_in;
    logic          driv_shift, strb_shift;
    logic [4:0]    driv_front, strb_back, strb_front;
    logic          busy, done, tmo_err;
    logic [7:0]    fail_cnt;
    logic [AW-1:0] first_fail_pc, pc;

    always #5 clk = ~clk;

    ate_pattern_seq dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .abort(abort),
        .cfg_strb_shift(cfg_strb_shift), .cfg_strb_back(cfg_strb_back), .cfg_strb_front(cfg_strb_front),
        .cfg_driv_shift(cfg_driv_shift), .cfg_driv_front(cfg_driv_front),
        .strb_data(strb_data), .strb_valid(strb_valid), .mr_out(mr_out),
        .r(r), .w(w), .mrw(mrw), .mrr(mrr), .addr(addr), .mr_in(mr_in), .dq_in(dq_in),
        .driv(driv), .driv_shift(driv_shift), .driv_front(driv_front),
        .strb(strb), .strb_shift(strb_shift), .strb_back(strb_back), .strb_front(strb_front),
        .busy(busy), .done(done), .fail_cnt(fail_cnt), .first_fail_pc(first_fail_pc),
        .tmo_err(tmo_err), .pc(pc)
    );

    int errors = 0;
    int checks = 0;

    logic [5:0]  seen_mask;
    int          pulse_cycles;
    logic [7:0]  p_addr, p_data;
    logic [10:0] p_cfg;
    int          busy_cycles;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  sdata;
        logic [7:0]  mrout;
        logic [5:0]  mask;
        logic [7:0]  paddr;
        logic [7:0]  pdata;
        logic [10:0] pcfg;
        int          cyc;
        logic [7:0]  fails;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] vw(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                                       input logic [7:0] e, input logic [4:0] wt);
        return {op, a, d, e, wt};
    endfunction

    function automatic logic any_out();
        return |{r, w, mrw, mrr, addr, mr_in, dq_in, driv, driv_shift, driv_front, strb, strb_shift,
                 strb_back, strb_front, busy, done, fail_cnt, first_fail_pc, tmo_err, pc};
    endfunction

    task automatic load(input int a, input logic [31:0] word);
        ld_en   = 1'b1;
        ld_addr = a[AW-1:0];
        ld_data = word;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic capture();
        logic [5:0] m;
        m = {r, w, mrw, mrr, driv, strb};
        if (m != 6'b0) begin
            seen_mask = seen_mask | m;
            pulse_cycles++;
            p_addr = addr;
            if (w) begin
                p_data = dq_in;
                p_cfg  = {5'b0, driv_shift, driv_front};
            end
            if (mrw) p_data = mr_in;
            if (r) p_cfg = {strb_shift, strb_back, strb_front};
        end
    endtask

    task automatic run_start();
        seen_mask    = '0;
        pulse_cycles = 0;
        p_addr       = '0;
        p_data       = '0;
        p_cfg        = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_wait(input int max);
        busy_cycles = 0;
        while (busy && busy_cycles < max) begin
            capture();
            busy_cycles++;
            @(negedge clk);
        end
        chk("run_bound", busy, 1'b0);
    endtask

    task automatic wait_r(input string name);
        int k = 0;
        while (!r && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(name, r, 1'b1);
    endtask

    initial begin
        tbl[0] = '{vw(3'd0, 8'h33, 8'h44, 8'h00, 5'd0), 8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 11'h000, 6, 8'd0};
        tbl[1] = '{vw(3'd1, 8'h10, 8'hA5, 8'h00, 5'd0), 8'h00, 8'h00, 6'b010010, 8'h10, 8'hA5, 11'h02B, 6, 8'd0};
        tbl[2] = '{vw(3'd2, 8'h10, 8'h00, 8'hA5, 5'd0), 8'hA5, 8'h00, 6'b100001, 8'h10, 8'h00, 11'h623, 7, 8'd0};
        tbl[3] = '{vw(3'd2, 8'h20, 8'h00, 8'h5A, 5'd0), 8'hA5, 8'h00, 6'b100001, 8'h20, 8'h00, 11'h623, 7, 8'd1};
        tbl[4] = '{vw(3'd3, 8'h02, 8'h3C, 8'h00, 5'd0), 8'h00, 8'h00, 6'b001000, 8'h02, 8'h3C, 11'h000, 6, 8'd0};
        tbl[5] = '{vw(3'd4, 8'h02, 8'h00, 8'h3C, 5'd0), 8'h00, 8'h3C, 6'b000100, 8'h02, 8'h00, 11'h000, 7, 8'd0};
        tbl[6] = '{vw(3'd4, 8'h02, 8'h00, 8'h3C, 5'd0), 8'h00, 8'h3D, 6'b000100, 8'h02, 8'h00, 11'h000, 7, 8'd1};
        tbl[7] = '{vw(3'd5, 8'h00, 8'h00, 8'h00, 5'd7), 8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 11'h000, 13, 8'd0};
        tbl[8] = '{vw(3'd6, 8'h55, 8'h66, 8'h00, 5'd0), 8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 11'h000, 6, 8'd0};
        tbl[9] = '{vw(3'd1, 8'h7F, 8'h01, 8'h00, 5'd2), 8'h00, 8'h00, 6'b010010, 8'h7F, 8'h01, 11'h02B, 8, 8'd0};

        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; abort = 1'b0;
        cfg_strb_shift = 1'b1; cfg_strb_back = 5'h11; cfg_strb_front = 5'h03;
        cfg_driv_shift = 1'b1; cfg_driv_front = 5'h0B;
        strb_data = 8'h00; strb_valid = 1'b0; mr_out = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", any_out(), 1'b0);

        // Single vector followed by END at PC 1
        for (int i = 0; i < 10; i++) begin
            load(0, tbl[i].word);
            load(1, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
            strb_data  = tbl[i].sdata;
            mr_out     = tbl[i].mrout;
            strb_valid = 1'b1;
            run_start();
            run_wait(200);
            chk($sformatf("t%0d_mask", i), seen_mask, tbl[i].mask);
            chk($sformatf("t%0d_pulses", i), pulse_cycles, (tbl[i].mask != 6'b0) ? 1 : 0);
            chk($sformatf("t%0d_addr", i), p_addr, tbl[i].paddr);
            chk($sformatf("t%0d_data", i), p_data, tbl[i].pdata);
            chk($sformatf("t%0d_cfg", i), p_cfg, tbl[i].pcfg);
            chk($sformatf("t%0d_cycles", i), busy_cycles, tbl[i].cyc);
            chk($sformatf("t%0d_fails", i), fail_cnt, tbl[i].fails);
            chk($sformatf("t%0d_done", i), done, 1'b1);
            chk($sformatf("t%0d_pc", i), pc, 1);
        end

        // WR then RD then END; done clears on the new start
        load(0, vw(3'd1, 8'h10, 8'hA5, 8'h00, 5'd0));
        load(1, vw(3'd2, 8'h10, 8'h00, 8'hA5, 5'd0));
        load(2, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        strb_data = 8'hA5; strb_valid = 1'b1;
        run_start();
        chk("wrrd_done_cleared", done, 1'b0);
        chk("wrrd_busy", busy, 1'b1);
        run_wait(200);
        chk("wrrd_mask", seen_mask, 6'b110011);
        chk("wrrd_cycles", busy_cycles, 10);
        chk("wrrd_fails", fail_cnt, 0);
        chk("wrrd_done", done, 1'b1);

        // Two mismatching reads: first fail PC sticks at the first one
        for (int i = 0; i < 8; i++) load(i, vw(3'd0, 8'h00, 8'h00, 8'h00, 5'd0));
        load(3, vw(3'd2, 8'h01, 8'h00, 8'h5A, 5'd0));
        load(6, vw(3'd2, 8'h02, 8'h00, 8'h5A, 5'd0));
        load(7, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        run_start();
        run_wait(200);
        chk("mf_fails", fail_cnt, 2);
        chk("mf_first_pc", first_fail_pc, 3);
        chk("mf_tmo", tmo_err, 1'b0);

        // Read that never returns data times out after 64 CHECK cycles and continues
        load(0, vw(3'd0, 8'h00, 8'h00, 8'h00, 5'd0));
        load(1, vw(3'd2, 8'h09, 8'h00, 8'h00, 5'd0));
        load(2, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        strb_valid = 1'b0;
        run_start();
        run_wait(200);
        chk("tmo_cycles", busy_cycles, 73);
        chk("tmo_err", tmo_err, 1'b1);
        chk("tmo_fails", fail_cnt, 1);
        chk("tmo_first_pc", first_fail_pc, 1);
        chk("tmo_pc", pc, 2);

        // Valid arriving in the 64th CHECK cycle still counts as a good read
        load(0, vw(3'd2, 8'h09, 8'h00, 8'hA5, 5'd0));
        load(1, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        strb_data = 8'hA5; strb_valid = 1'b0;
        run_start();
        wait_r("late_r_seen");
        repeat (64) @(negedge clk);
        strb_valid = 1'b1;
        run_wait(200);
        chk("late_tmo", tmo_err, 1'b0);
        chk("late_fails", fail_cnt, 0);

        // 32 NOPs without END stop at PC 31
        for (int i = 0; i < 32; i++) load(i, vw(3'd0, 8'h00, 8'h00, 8'h00, 5'd0));
        run_start();
        run_wait(200);
        chk("nop32_cycles", busy_cycles, 97);
        chk("nop32_pc", pc, 31);
        chk("nop32_done", done, 1'b1);

        // Loads while busy are dropped
        load(0, vw(3'd0, 8'h00, 8'h00, 8'h00, 5'd10));
        load(1, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        run_start();
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'd1; ld_data = vw(3'd1, 8'h44, 8'h55, 8'h00, 5'd0);
        @(negedge clk);
        ld_en = 1'b0;
        run_wait(200);
        chk("ldbusy_mask", seen_mask, 6'b0);
        chk("ldbusy_cycles", busy_cycles + 2, 16);

        // ABORT together with START mid-run
        run_start();
        repeat (4) @(negedge clk);
        chk("abort_pre_busy", busy, 1'b1);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b1);
        chk("abort_pulses", |{r, w, mrw, mrr, driv, strb}, 1'b0);
        @(negedge clk);
        chk("abort_stays_idle", busy, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_done", done, 1'b1);

        // Reset during CHECK, then a clean rerun
        load(0, vw(3'd2, 8'h09, 8'h00, 8'h00, 5'd0));
        load(1, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        strb_valid = 1'b0;
        run_start();
        wait_r("rst_r_seen");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", any_out(), 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load(0, vw(3'd1, 8'h21, 8'h3C, 8'h00, 5'd0));
        load(1, vw(3'd7, 8'h00, 8'h00, 8'h00, 5'd0));
        strb_valid = 1'b1;
        run_start();
        run_wait(200);
        chk("rerun_mask", seen_mask, 6'b010010);
        chk("rerun_cycles", busy_cycles, 6);
        chk("rerun_pc", pc, 1);
        chk("rerun_data", p_data, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ate_pattern_seq.md
Name: ate_pattern_seq

Overview:
Vector-driven test sequencer that sits in front of the ATE top level and drives its DRAM command, Driver and Sampler inputs. Software preloads a DEPTH-entry vector memory and pulses START. The block then issues each vector as a 1-cycle command and checks read data against expected values. It also counts mismatches and reports completion, with no per-cycle software involvement.

Parameters:
DEPTH, 32, vector memory entries (power of 2; PC width AW = log2(DEPTH) = 5)
TIMEOUT, 64, max cycles to wait for STRB_VALID after a RD issue

Ports:
CLK  in  1  clock, all logic rising-edge
RST_N  in  1  asynchronous active-low reset
LD_EN  in  1  vector memory write strobe
LD_ADDR  in  AW  vector memory write address
LD_DATA  in  32  vector word: [31:29] op, [28:21] addr, [20:13] data, [12:5] expect, [4:0] wait
START  in  1  run request pulse
ABORT  in  1  stop request pulse
CFG_STRB_SHIFT / CFG_STRB_BACK[4:0] / CFG_STRB_FRONT[4:0]  in  1/5/5  strobe window, forwarded on RD
CFG_DRIV_SHIFT / CFG_DRIV_FRONT[4:0]  in  1/5  drive offset, forwarded on WR
STRB_DATA  in  8  sampled data from Sampler
STRB_VALID  in  1  sample valid from Sampler
MR_OUT  in  8  mode register read data from DRAM
R, W, MRW, MRR  out  1  DRAM command pulses
ADDR  out  8  DRAM address
MR_IN  out  8  mode register write data
DQ_IN  out  8  drive data
DRIV  out  1  drive pulse
DRIV_SHIFT / DRIV_FRONT  out  1/5  drive offset
STRB  out  1  strobe pulse
STRB_SHIFT / STRB_BACK / STRB_FRONT  out  1/5/5  strobe window
BUSY  out  1  sequence running
DONE  out  1  sticky, set at sequence end
FAIL_CNT  out  8  mismatch count, saturates at 255
FIRST_FAIL_PC  out  AW  PC of the first failing vector
TMO_ERR  out  1  sticky, a RD timed out
PC  out  AW  current vector index

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Vector memory contents are undefined after reset.
- Opcodes:
  - 0 NOP, 1 WR, 2 RD, 3 MRW, 4 MRR, 5 WAIT, 7 END.
  - 6 is reserved and executes as NOP.
- All outputs are registered. Command pulses are high for exactly one cycle and are 0 in every non-ISSUE cycle.
- LD_EN:
  - Writes memory only while BUSY=0. Ignored while BUSY=1.
- States: IDLE, FETCH, ISSUE, CHECK, WAITCNT, DONE_ST.
  - IDLE:
    - START -> FETCH.
    - On entry to FETCH: PC=0, FAIL_CNT=0, FIRST_FAIL_PC=0, TMO_ERR=0, DONE=0, BUSY=1.
    - START is ignored while BUSY=1.
  - FETCH:
    - Synchronous memory read, 1 cycle -> ISSUE.
  - ISSUE:
    - WR: W=1, ADDR=addr, DRIV=1, DQ_IN=data, DRIV_SHIFT/DRIV_FRONT=CFG values.
    - RD: R=1, ADDR=addr, STRB=1, STRB_* = CFG values. Next state is CHECK.
    - MRW: MRW=1, ADDR=addr, MR_IN=data.
    - MRR: MRR=1, ADDR=addr. Next state is CHECK.
    - NOP/WAIT: no pulse.
    - END: next state is DONE_ST.
    - All others go to WAITCNT.
  - CHECK, RD:
    - Waits for STRB_VALID, counting up to TIMEOUT cycles.
    - On valid: if STRB_DATA != expect, record a fail.
    - At TIMEOUT cycles with no valid: record a fail and set TMO_ERR.
    - A STRB_VALID arriving in the same cycle as the timeout counts as valid.
  - CHECK, MRR:
    - Compares MR_OUT in the first CHECK cycle (1 cycle after the MRR pulse) against expect.
  - Record fail:
    - FAIL_CNT += 1, saturating at 255.
    - FIRST_FAIL_PC = PC only if FAIL_CNT was 0.
  - WAITCNT:
    - Idles for wait cycles; 0 means none.
    - Then, if PC == DEPTH-1 -> DONE_ST (no wrap). Otherwise PC += 1 -> FETCH.
    - WAIT with wait=0 therefore behaves as NOP.
  - DONE_ST:
    - DONE=1, BUSY=0, then -> IDLE.
    - DONE stays set until the next accepted START.
    - FAIL_CNT, FIRST_FAIL_PC and TMO_ERR hold until the next accepted START.
- ABORT (any state with BUSY=1):
  - Next cycle: state IDLE, BUSY=0, all command pulses 0, DONE=1.
  - ABORT wins over START in the same cycle.
  - ABORT in IDLE has no effect.
- Timing: each non-read vector takes 2 + wait cycles (FETCH, ISSUE) plus 1 WAITCNT cycle. RD and MRR vectors add their CHECK cycles.
- Reset mid-run: immediate return to the reset values above, asynchronously.

Test Plan:
1. Load {0: WR addr 0x10 data 0xA5, 1: RD addr 0x10 expect 0xA5, 2: END}; START -> W pulse with ADDR=0x10, DQ_IN=0xA5, DRIV=1; then R pulse and STRB=1; DONE=1, FAIL_CNT=0, BUSY falls.
2. RD with expect 0x5A while the bench returns STRB_DATA=0xA5 at PC=3 -> FAIL_CNT=1, FIRST_FAIL_PC=3; a second mismatch at PC=6 -> FAIL_CNT=2 and FIRST_FAIL_PC stays 3.
3. RD with STRB_VALID held low -> after 64 CHECK cycles TMO_ERR=1, FAIL_CNT=1, and the sequence continues to the next vector.
4. MRW addr 2 data 0x3C, then MRR addr 2 expect 0x3C with MR_OUT=0x3C -> MRW pulse with MR_IN=0x3C, no fail; a WAIT vector with wait=7 inserts exactly 7 idle cycles.
5. 32 NOPs with no END -> DONE after PC=31, no wrap; ABORT asserted together with START mid-run -> BUSY=0 and DONE=1 next cycle; LD_EN while BUSY leaves memory unchanged.
6. RST_N pulsed low during CHECK -> all outputs 0 immediately; a subsequent START runs from PC=0.
